pin_entry_sequencer: RTL



---
 rtl/bank_safe_pkg.sv | 31 +++
 rtl/btn_edge_detect.sv | 28 ++
 rtl/pin_entry_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bank_safe_pkg.sv
// +--------------------------------------------------------------------------+
// | bank_safe_pkg : shared states and constants for the safe's PIN path      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package bank_safe_pkg;

  localparam int unsigned C_DEFAULT_PIN_WIDTH = 4;
  localparam logic [3:0]  C_REF_PIN           = 4'b1010;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    SUBMIT  = 3'd2,
    WAIT    = 3'd3,
    OPEN    = 3'd4,
    FAIL    = 3'd5,
    LOCKOUT = 3'd6
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_edge_detect.sv
// +--------------------------------------------------------------------------+
// | btn_edge_detect : 1-bit rising-edge detector, history resets to 1        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module btn_edge_detect
  import bank_safe_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  logic hist_q;

  // History resets high so a button held through reset never reads as a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) hist_q <= 1'b1;
    else       hist_q <= btn_i;
  end

  assign press_o = btn_i & ~hist_q;

endmodule

`default_nettype wire

// File: rtl/pin_entry_sequencer.sv
// +--------------------------------------------------------------------------+
// | pin_entry_sequencer : serial PIN entry, checker handshake, open/lockout  |
// | Optional: `define ENTRY_TIMEOUT_EN aborts stalled entries. Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module pin_entry_sequencer
  import bank_safe_pkg::*;
#(
  parameter int unsigned PIN_WIDTH     = C_DEFAULT_PIN_WIDTH,
  parameter int unsigned MAX_TRIES     = 3,
  parameter int unsigned CHECK_LATENCY = 1,
  parameter int unsigned OPEN_CYCLES   = 50000000,
  parameter int unsigned LOCK_CYCLES   = 250000000,
  parameter int unsigned ENTRY_TIMEOUT = 500000000
) (
  input  logic                             ClockSource,
  input  logic                             Reset,
  input  logic                             BtnZero,
  input  logic                             BtnOne,
  input  logic                             BtnEnter,
  input  logic                             Valid,
  output logic [PIN_WIDTH-1:0]             UserPIN,
  output logic                             PinStrobe,
  output logic                             Unlocked,
  output logic                             LockedOut,
  output logic [$clog2(MAX_TRIES+1)-1:0]   AttemptsLeft
);

  localparam int unsigned AW = $clog2(MAX_TRIES + 1);
  localparam int unsigned CW = $clog2(PIN_WIDTH + 1);
  localparam int unsigned TW = $clog2(max3(OPEN_CYCLES, LOCK_CYCLES, ENTRY_TIMEOUT) + 1);

  state_e               state_q;
  logic [PIN_WIDTH-1:0] shift_q;
  logic [PIN_WIDTH-1:0] user_pin_q;
  logic [CW-1:0]        cnt_q;
  logic [AW-1:0]        fail_q;
  logic [AW-1:0]        attempts_q;
  logic [TW-1:0]        timer_q;
  logic                 strobe_q;
  logic                 unlocked_q;
  logic                 locked_q;

  logic                 w_press_zero;
  logic                 w_press_one;
  logic                 w_press_enter;
  logic                 w_bit_press;
  logic [AW-1:0]        fail_d;

  btn_edge_detect u_edge_zero  (.clk_i(ClockSource), .rst_i(Reset), .btn_i(BtnZero),  .press_o(w_press_zero));
  btn_edge_detect u_edge_one   (.clk_i(ClockSource), .rst_i(Reset), .btn_i(BtnOne),   .press_o(w_press_one));
  btn_edge_detect u_edge_enter (.clk_i(ClockSource), .rst_i(Reset), .btn_i(BtnEnter), .press_o(w_press_enter));

  // Zero and One together cancel; Enter in the same cycle wins over either.
  assign w_bit_press = (w_press_zero ^ w_press_one) & ~w_press_enter;
  assign fail_d      = fail_q + 1'b1;

  always_ff @(posedge ClockSource) begin
    if (Reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      user_pin_q <= '0;
      cnt_q      <= '0;
      fail_q     <= '0;
      attempts_q <= AW'(MAX_TRIES);
      timer_q    <= '0;
      strobe_q   <= 1'b0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      attempts_q <= AW'(MAX_TRIES) - fail_q;
      strobe_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_bit_press) begin
            shift_q <= PIN_WIDTH'(w_press_one);
            cnt_q   <= CW'(1);
            timer_q <= '0;
            state_q <= ENTRY;
          end
        end
        ENTRY: begin
          if (w_press_enter) begin
            if (cnt_q == CW'(PIN_WIDTH)) begin
              user_pin_q <= shift_q;
              strobe_q   <= 1'b1;
              state_q    <= SUBMIT;
            end else begin
              state_q <= FAIL;
            end
          end else if (w_bit_press && (cnt_q != CW'(PIN_WIDTH))) begin
            shift_q <= PIN_WIDTH'({shift_q, w_press_one});
            cnt_q   <= cnt_q + 1'b1;
            timer_q <= '0;
          end
`ifdef ENTRY_TIMEOUT_EN
          else if (timer_q == TW'(ENTRY_TIMEOUT - 1)) begin
            shift_q <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`else
          else begin
            timer_q <= timer_q;
          end
`endif
        end
        SUBMIT: begin
          // Counts cycles since SUBMIT so Valid is taken on the CHECK_LATENCY-th.
          timer_q <= TW'(1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (timer_q >= TW'(CHECK_LATENCY)) begin
            timer_q <= '0;
            if (Valid) begin
              unlocked_q <= 1'b1;
              user_pin_q <= '0;
              fail_q     <= '0;
              state_q    <= OPEN;
            end else begin
              state_q <= FAIL;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        OPEN: begin
          if (timer_q == TW'(OPEN_CYCLES - 1)) begin
            unlocked_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        FAIL: begin
          fail_q     <= fail_d;
          shift_q    <= '0;
          cnt_q      <= '0;
          user_pin_q <= '0;
          timer_q    <= '0;
          if (fail_d == AW'(MAX_TRIES)) begin
            locked_q <= 1'b1;
            state_q  <= LOCKOUT;
          end else begin
            state_q <= IDLE;
          end
        end
        LOCKOUT: begin
          if (timer_q == TW'(LOCK_CYCLES - 1)) begin
            locked_q <= 1'b0;
            fail_q   <= '0;
            timer_q  <= '0;
            state_q  <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign UserPIN      = user_pin_q;
  assign PinStrobe    = strobe_q;
  assign Unlocked     = unlocked_q;
  assign LockedOut    = locked_q;
  assign AttemptsLeft = attempts_q;

endmodule

`default_nettype wire
